adder_share_ctrl: RTL and testbench



---
 rtl/adder_share_pkg.sv | 13 +
 rtl/adder_share_ctrl_if.sv | 19 +
 rtl/adder_rsp_fifo.sv | 38 +++
 rtl/adder_share_ctrl.sv | 69 ++++++
 tb/tb_adder_share_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared defaults, id-width helper and tag type for the adder-sharing controller.
package adder_share_pkg;
    localparam int WIDTH_DEF   = 12;
    localparam int ADD_LAT_DEF = 2;
    localparam int MAX_ID_W    = 3;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/adder_share_ctrl_if.sv
// adder_share_ctrl_if: requester and response handshake bundle.
interface adder_share_ctrl_if import adder_share_pkg::*; #(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int ID_W = id_w(NREQ);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic [ID_W-1:0]       rsp_id;
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_sum, rsp_id);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_sum, rsp_id);
endinterface

// File: rtl/adder_rsp_fifo.sv
// adder_rsp_fifo: first-word fall-through response FIFO with occupancy count.
module adder_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 14,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd];
    always_ff @(posedge clk)
        if (push) mem[wr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= nxt(wr);
            if (pop) rd <= nxt(rd);
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sharing of one registered adder among NREQ requesters,
// with id tags tracked through the adder latency and credit-limited issue into a response FIFO.
module adder_share_ctrl import adder_share_pkg::*; #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADD_LAT    = ADD_LAT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_ctrl_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_c
);
    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    logic [ID_W-1:0]       ptr, gnt;
    logic                  gnt_any, issue, pop, fifo_empty;
    logic [CNT_W-1:0]      outstanding, fifo_count;
    logic [ID_W+WIDTH-1:0] fifo_dout;
    tag_t                  tags [ADD_LAT];
    // Scan downward so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt     = ID_W'((int'(ptr) + k) % NREQ);
            end
    end
    assign issue         = rst_n && gnt_any && (outstanding < CNT_W'(FIFO_DEPTH));
    assign bus.req_ready = issue ? NREQ'(1) << gnt : '0;
    assign add_a         = issue ? bus.req_a[gnt*WIDTH +: WIDTH] : '0;
    assign add_b         = issue ? bus.req_b[gnt*WIDTH +: WIDTH] : '0;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr         <= '0;
            outstanding <= '0;
        end else begin
            if (issue) ptr <= (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
            if (issue != pop) outstanding <= issue ? outstanding + 1'b1 : outstanding - 1'b1;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: issue, id: MAX_ID_W'(gnt)};
            for (int i = 1; i < ADD_LAT; i++) tags[i] <= tags[i-1];
        end
    adder_rsp_fifo #(.DEPTH(FIFO_DEPTH), .W(ID_W + WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tags[ADD_LAT-1].valid),
        .din   ({tags[ADD_LAT-1].id[ID_W-1:0], add_c}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_sum   = fifo_dout[WIDTH-1:0];
    assign bus.rsp_id    = fifo_dout[ID_W+WIDTH-1:WIDTH];
    assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= outstanding);
    assert property (@(posedge clk) disable iff (!rst_n)
        !tags[ADD_LAT-1].valid || int'(tags[ADD_LAT-1].id) < NREQ);
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: random and directed stimulus against a queue-based reference model of the adder sharer.
module tb_adder_share_ctrl;
    localparam int NREQ  = 4;
    localparam int W     = 12;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [W-1:0] add_a, add_b, add_c, a_r, b_r;
    adder_share_ctrl_if #(.NREQ(NREQ), .WIDTH(W)) bus ();
    adder_share_ctrl #(.NREQ(NREQ), .WIDTH(W), .ADD_LAT(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .add_a (add_a),
        .add_b (add_b),
        .add_c (add_c)
    );
    // External shared adder: input register then output register, never reset.
    always @(posedge clk) begin
        a_r   <= add_a;
        b_r   <= add_b;
        add_c <= a_r + b_r;
    end
    typedef struct {
        int id;
        int sum;
        int cyc;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int ptr = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Reference: credit = responses still owed, grant = first valid requester from ptr.
    always @(negedge clk) begin : model
        int g, ea, eb;
        logic [NREQ-1:0] er;
        if (!rst_n) begin
            q.delete();
            ptr = 0;
            chk("ready_in_reset", bus.req_ready, 0);
        end else begin
            g = -1;
            er = '0;
            ea = 0;
            eb = 0;
            if (q.size() < DEPTH)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && bus.req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            if (g >= 0) begin
                er[g] = 1'b1;
                ea = int'(bus.req_a[g*W +: W]);
                eb = int'(bus.req_b[g*W +: W]);
                q.push_back('{id: g, sum: (ea + eb) % (1 << W), cyc: cyc});
                ptr = (g + 1) % NREQ;
            end
            chk("req_ready", bus.req_ready, er);
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
        end
    end
    always @(negedge clk) begin : monitor
        logic exp_v;
        #1;
        if (rst_n) begin
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (cyc >= q[0].cyc + 3);
            chk("rsp_valid", bus.rsp_valid, exp_v);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    chk("rsp_sum", bus.rsp_sum, q[0].sum);
                    chk("rsp_id", bus.rsp_id, q[0].id);
                    void'(q.pop_front());
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = W'($urandom);
            bus.req_b[i*W +: W] = W'($urandom);
        end
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_sum"}, bus.rsp_sum, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
    endtask
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) step();
        bus.req_valid = '1;
        #1;
        check_reset_outputs("por");
        bus.req_valid = '0;
        rst_n = 1'b1;
        step();
        // single op from requester 0
        bus.req_a[0 +: W] = 12'h123;
        bus.req_b[0 +: W] = 12'h456;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = '0;
        repeat (5) step();
        // modular wrap from requester 2
        bus.req_a[2*W +: W] = 12'hFFF;
        bus.req_b[2*W +: W] = 12'h001;
        bus.req_valid = 4'b0100;
        step();
        bus.req_a[2*W +: W] = 12'h800;
        bus.req_b[2*W +: W] = 12'h800;
        step();
        bus.req_valid = '0;
        repeat (5) step();
        // continuous contention
        bus.req_valid = '1;
        repeat (8) begin rand_ops(); step(); end
        bus.req_valid = '0;
        repeat (5) step();
        // backpressure: credits exhaust, then drain
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        repeat (8) begin rand_ops(); step(); end
        bus.rsp_ready = 1'b1;
        repeat (8) begin rand_ops(); step(); end
        bus.req_valid = '0;
        repeat (6) step();
        // full FIFO with toggling consumer
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        repeat (24) begin rand_ops(); bus.rsp_ready = ~bus.rsp_ready; step(); end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (8) step();
        // asynchronous reset with two ops in flight
        bus.req_valid = '1;
        rand_ops();
        step();
        rand_ops();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin rand_ops(); step(); end
        bus.req_valid = '0;
        repeat (5) step();
        // randomized traffic
        repeat (300) begin
            rand_ops();
            bus.req_valid = NREQ'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        chk("drain_left", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
